// File: rtl/gate16_bist_pkg.sv
// Shared definitions for the gate16 BIST engine: op codes, state encoding,
// LFSR mask, corner vectors and the golden gate model.
package gate16_bist_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } vec_t;

  localparam logic [15:0] LFSR_MASK   = 16'hB400;
  localparam logic [15:0] CORNER_ZERO = 16'h0000;
  localparam logic [15:0] CORNER_ONES = 16'hFFFF;
  localparam logic [15:0] NO_FAIL     = 16'hFFFF;
  localparam int unsigned N_CORNER    = 4;

  // Corner vectors 0..3 walk (a,b) through (0,0), (0,1s), (1s,0), (1s,1s).
  function automatic vec_t corner_vec(input logic [1:0] idx);
    vec_t v;
    v.a = idx[1] ? CORNER_ONES : CORNER_ZERO;
    v.b = idx[0] ? CORNER_ONES : CORNER_ZERO;
    return v;
  endfunction

  // Pseudo-random vectors use the LFSR state for a and its byte swap for b.
  function automatic vec_t lfsr_vec(input logic [15:0] state);
    vec_t v;
    v.a = state;
    v.b = {state[7:0], state[15:8]};
    return v;
  endfunction

  function automatic logic [15:0] gate_eval(input op_e op, input logic [15:0] a,
                                            input logic [15:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

endpackage

// File: rtl/gate16_bist_if.sv
// Gate-under-test connection: the BIST (master) drives operands and samples
// the result; the gate (slave) consumes operands and returns y.
interface gate16_bist_if;
  logic [15:0] dut_a;
  logic [15:0] dut_b;
  logic [15:0] dut_y;

  modport master (output dut_a, output dut_b, input dut_y);
  modport slave  (input dut_a, input dut_b, output dut_y);
endinterface

// File: rtl/gate16_lfsr.sv
// 16-bit right-shifting Galois LFSR with synchronous load and step; q_next
// exposes the value the next step will produce.
module gate16_lfsr
  import gate16_bist_pkg::*;
#(
  parameter logic [15:0] MASK = LFSR_MASK
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        step,
  output logic [15:0] q,
  output logic [15:0] q_next
);

  assign q_next = q[0] ? ((q >> 1) ^ MASK) : (q >> 1);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 16'h0001;
    end else if (load) begin
      q <= load_val;
    end else if (step) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/gate16_bist.sv
// gate16_bist: drives corner and LFSR vectors into a 16-bit gate, compares y
// against a golden model and reports pass / error count / first failing index.
// Optional GATE16_BIST_FORCE_ERR_EN adds inj_err, which corrupts golden bit 0.
module gate16_bist
  import gate16_bist_pkg::*;
#(
  parameter int unsigned N_VEC  = 16,
  parameter int unsigned SETTLE = 1,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op,
`ifdef GATE16_BIST_FORCE_ERR_EN
  input  logic          inj_err,
`endif
  gate16_bist_if.master gate,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_count,
  output logic [15:0]   first_fail_idx
);

  localparam int unsigned      CNT_W       = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE);
  localparam logic [15:0]      LAST_IDX    = 16'(N_VEC - 1);
  localparam logic [15:0]      FIRST_LFSR  = 16'(N_CORNER);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [15:0]      idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  vec_t             vec_q, vec_d;
  logic             busy_d, done_d, pass_d;
  logic [15:0]      err_d, ffi_d;

  logic             lfsr_load, lfsr_step;
  logic [15:0]      lfsr_q, lfsr_next;
  logic             inj;
  logic [15:0]      golden;
  logic             mismatch;

  gate16_lfsr u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .load_val (SEED),
    .step     (lfsr_step),
    .q        (lfsr_q),
    .q_next   (lfsr_next)
  );

`ifdef GATE16_BIST_FORCE_ERR_EN
  assign inj = inj_err;
`else
  assign inj = 1'b0;
`endif

  // Golden is computed from the registered operands, i.e. exactly what the gate sees.
  assign golden   = gate_eval(op_q, vec_q.a, vec_q.b) ^ {15'd0, inj};
  assign mismatch = (gate.dut_y != golden);

  assign gate.dut_a = vec_q.a;
  assign gate.dut_b = vec_q.b;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    vec_d     = vec_q;
    busy_d    = busy;
    done_d    = done;
    pass_d    = pass;
    err_d     = err_count;
    ffi_d     = first_fail_idx;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          op_d      = op_e'(op);
          idx_d     = 16'd0;
          cnt_d     = '0;
          vec_d     = corner_vec(2'd0);
          lfsr_load = 1'b1;
          err_d     = 16'd0;
          ffi_d     = NO_FAIL;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_DRIVE;
        end
      end

      S_DRIVE: begin
        if (cnt_q != SETTLE_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          if (mismatch) begin
            if (err_count != 16'hFFFF) err_d = err_count + 16'd1;
            if (first_fail_idx == NO_FAIL) ffi_d = idx_q;
          end
          // The LFSR only advances once one of its own vectors has been sampled.
          lfsr_step = (idx_q >= FIRST_LFSR);

          if (idx_q == LAST_IDX) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 16'd0);
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 16'd1;
            cnt_d = '0;
            if (idx_d < FIRST_LFSR) begin
              vec_d = corner_vec(idx_d[1:0]);
            end else if (idx_q >= FIRST_LFSR) begin
              vec_d = lfsr_vec(lfsr_next);
            end else begin
              vec_d = lfsr_vec(lfsr_q);
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      op_q           <= OP_AND;
      idx_q          <= 16'd0;
      cnt_q          <= '0;
      vec_q          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 16'd0;
      first_fail_idx <= NO_FAIL;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      vec_q          <= vec_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      err_count      <= err_d;
      first_fail_idx <= ffi_d;
    end
  end

endmodule

// File: doc/gate16_bist.md
Name: gate16_bist

Overview:
- Sequential self-checking stimulus/response engine for 16-bit two-input combinational gates (the gand16/gor16/gxor16 family).
- Acts as the other end of the gate interface: it drives a/b into the DUT, samples y, and compares y against an internal golden model.
- Reports a pass flag, an error count and the index of the first failing vector.
- Used for in-simulation and on-silicon checking of the gate library.

Parameters:
- N_VEC, 16: number of vectors per run, range 1..65535.
- SETTLE, 1: extra hold cycles per vector before y is sampled, range ≥0.
- SEED, 16'hACE1: LFSR load value at start; must be nonzero.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins a run when sampled high in IDLE or DONE.
- op  in  2  golden operation: 00 AND, 01 OR, 10 XOR, 11 NAND. Latched at start.
- dut_a  out  16  operand a to the DUT.
- dut_b  out  16  operand b to the DUT.
- dut_y  in  16  DUT result.
- busy  out  1  run in progress.
- done  out  1  run finished; level, held until the next start or reset.
- pass  out  1  valid while done=1; equals (err_count==0).
- err_count  out  16  mismatching vectors, saturates at 16'hFFFF.
- first_fail_idx  out  16  index of the first mismatch; 16'hFFFF if none.

Behaviour:
- Reset (async, immediate): dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_count=0, first_fail_idx=16'hFFFF, state=IDLE. A reset mid-run aborts the run; there is no resume.
- States: IDLE, DRIVE, DONE.
- IDLE/DONE with start=1 at an edge:
  - latch op, idx=0, lfsr=SEED, clear err_count/first_fail_idx/done/pass;
  - drive vector 0; busy=1 from the next cycle; go to DRIVE.
- Start while busy=1 is ignored.
- Vector sequence:
  - idx0 (0000,0000); idx1 (0000,FFFF); idx2 (FFFF,0000); idx3 (FFFF,FFFF).
  - idx≥4: a=lfsr, b={lfsr[7:0],lfsr[15:8]}. Galois LFSR, mask 16'hB400, advanced once after each LFSR vector is sampled.
  - If N_VEC<4, only the first N_VEC corner vectors are used.
- DRIVE:
  - each vector is held SETTLE+1 cycles; dut_y is compared at the edge ending the last hold cycle;
  - golden = op applied to the registered dut_a/dut_b, all 16 bits.
- On mismatch:
  - err_count++ (saturating);
  - if first_fail_idx==FFFF, set it to idx.
- After the compare:
  - if idx==N_VEC-1 → DONE with busy=0, done=1, pass=(final err_count==0);
  - else idx++, present the next vector, restart the settle counter.
- Latency: done is visible after exactly N_VEC*(SETTLE+1) edges following the start-sampling edge.
- Outputs are registered; dut_a/dut_b change only at vector boundaries and hold their last vector in DONE.

Optional Feature:
- Macro GATE16_BIST_FORCE_ERR_EN.
- Defined:
  - adds input inj_err (1 bit);
  - when inj_err=1 at a compare edge, golden bit 0 is inverted, forcing that vector to mismatch;
  - used to prove the checker itself.
- Undefined: the port is absent and the compare is unmodified.

Decomposition:
- Shared package/include gate16_bist_pkg:
  - op codes (OP_AND, OP_OR, OP_XOR, OP_NAND);
  - LFSR_MASK 16'hB400;
  - corner-vector constants;
  - state encoding (S_IDLE, S_DRIVE, S_DONE).
- One sub-module, gate16_lfsr: 16-bit Galois LFSR with load, load_val and step inputs.
- The FSM, settle counter, golden model and error bookkeeping stay in gate16_bist.

Test Plan:
- N_VEC=16, SETTLE=1, op=OR, DUT=correct gor16, start pulse → busy=1 next cycle; done=1 after 32 edges; pass=1, err_count=0, first_fail_idx=FFFF.
- N_VEC=4, op=OR, DUT=AND gate → vectors 1 and 2 fail; err_count=2, first_fail_idx=1, pass=0.
- N_VEC=8, SETTLE=0, op=XOR, correct DUT → dut_a/b change every cycle; idx4 shows a=ACE1, b=E1AC; done after 8 edges, pass=1.
- rst_n low during idx5 → all outputs return to reset values asynchronously; after release they stay IDLE until start.
- start held high throughout the run → ignored while busy; a second start in DONE reruns with counts cleared and an identical sequence.
- GATE16_BIST_FORCE_ERR_EN defined, correct DUT, inj_err=1 during idx0 compare only → err_count=1, first_fail_idx=0, pass=0.
